// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 convolution MAC stage.
//   PROD_W        : width of one pixel*weight product (9b signed x 8b signed)
//   ROWSUM_W      : width of one row sum (3 products)
//   ACC_W         : width of the full accumulator (3 row sums + bias)
//   WGT_ADDR_BIAS : write address that selects the bias register
//   KERNEL_TAPS   : number of kernel weights (3x3)
//   frame_windows : number of valid 3x3 windows in one image frame
package conv_pkg;

  localparam int PROD_W        = 17;
  localparam int ROWSUM_W      = 19;
  localparam int ACC_W         = 22;
  localparam int WGT_ADDR_BIAS = 9;
  localparam int KERNEL_TAPS   = 9;

  // A 3x3 window without padding loses one pixel on every border.
  function automatic int frame_windows(input int img_w, input int img_h);
    return (img_w - 2) * (img_h - 2);
  endfunction

endpackage

// File: rtl/conv_row_mac.sv
// One window row of the 3x3 MAC: three signed multiplies (registered)
// followed by a registered 3-input adder.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   row        : three unsigned pixels {left, mid, right}, left in MSBs
//   wgt        : three signed weights, same packing as row
//   row_sum    : signed sum of the three products, two cycles after row
module conv_row_mac
  import conv_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int WGT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [3*PIX_W-1:0]         row,
  input  logic [3*WGT_W-1:0]         wgt,
  output logic signed [ROWSUM_W-1:0] row_sum
);

  logic signed [PROD_W-1:0] prod_c [3];
  logic signed [PROD_W-1:0] prod_q [3];

  for (genvar i = 0; i < 3; i++) begin : g_tap
    logic signed [PIX_W:0]   pix_s;
    logic signed [WGT_W-1:0] wgt_s;
    // Pixels are unsigned: a zero MSB turns them into non-negative signed values.
    assign pix_s     = {1'b0, row[(2-i)*PIX_W +: PIX_W]};
    assign wgt_s     = wgt[(2-i)*WGT_W +: WGT_W];
    assign prod_c[i] = PROD_W'(pix_s) * PROD_W'(wgt_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) prod_q[i] <= '0;
      row_sum <= '0;
    end else begin
      for (int i = 0; i < 3; i++) prod_q[i] <= prod_c[i];
      row_sum <= ROWSUM_W'(prod_q[0]) + ROWSUM_W'(prod_q[1]) + ROWSUM_W'(prod_q[2]);
    end
  end

endmodule

// File: rtl/conv3x3_mac_relu.sv
// 3x3 convolution with loadable kernel and bias, arithmetic right-shift
// requantisation, ReLU and unsigned saturation, plus a per-frame output
// counter.
// Ports:
//   iClk, iRsn                  : clock, asynchronous active-low reset
//   iWindowRow1..3              : window rows {left, mid, right}, left in MSBs
//   iWindowValid                : window rows valid this cycle
//   iWgtWrEn/iWgtAddr/iWgtData  : kernel (addr 0..8 = r*3+c) / bias (addr 9) write
//   oPixelOut, oPixelValid      : result pixel and its valid
//   oFrameDone                  : pulse with the last pixel of a frame
//   oSatFlag                    : sticky positive-saturation flag
// Handshake: valid-only stream. A window is taken on every edge where
// iWindowValid=1 and its pixel appears with oPixelValid=1 exactly four edges
// later; there is no ready, the stage always accepts and never stalls.
module conv3x3_mac_relu
  import conv_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int WGT_W  = 8,
  parameter int BIAS_W = 16,
  parameter int SHIFT  = 4,
  parameter int OUT_W  = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic               iClk,
  input  logic               iRsn,
  input  logic [3*PIX_W-1:0] iWindowRow1,
  input  logic [3*PIX_W-1:0] iWindowRow2,
  input  logic [3*PIX_W-1:0] iWindowRow3,
  input  logic               iWindowValid,
  input  logic               iWgtWrEn,
  input  logic [3:0]         iWgtAddr,
  input  logic [BIAS_W-1:0]  iWgtData,
  output logic [OUT_W-1:0]   oPixelOut,
  output logic               oPixelValid,
  output logic               oFrameDone,
  output logic               oSatFlag
);

  localparam int                      N_WIN    = frame_windows(IMG_W, IMG_H);
  localparam int                      CNT_W    = 10;
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(N_WIN - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX  = ACC_W'((1 << OUT_W) - 1);

  // Kernel and bias registers
  logic signed [WGT_W-1:0]  wgt [KERNEL_TAPS];
  logic signed [BIAS_W-1:0] bias;

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      for (int i = 0; i < KERNEL_TAPS; i++) wgt[i] <= '0;
      bias <= '0;
    end else if (iWgtWrEn) begin
      if (iWgtAddr == 4'(WGT_ADDR_BIAS)) bias <= iWgtData;
      for (int i = 0; i < KERNEL_TAPS; i++) begin
        if (iWgtAddr == 4'(i)) wgt[i] <= iWgtData[WGT_W-1:0];
      end
    end
  end

  // S1-S2: per-row multiply and row sum. The products register the weights
  // as they stand before this edge, so a same-edge write affects only later windows.
  logic [3*PIX_W-1:0]         rows    [3];
  logic signed [ROWSUM_W-1:0] row_sum [3];

  assign rows[0] = iWindowRow1;
  assign rows[1] = iWindowRow2;
  assign rows[2] = iWindowRow3;

  for (genvar r = 0; r < 3; r++) begin : g_row
    logic [3*WGT_W-1:0] wgt_row;
    assign wgt_row = {wgt[3*r], wgt[3*r+1], wgt[3*r+2]};
    conv_row_mac #(.PIX_W(PIX_W), .WGT_W(WGT_W)) u_row (
      .clk     (iClk),
      .rst_n   (iRsn),
      .row     (rows[r]),
      .wgt     (wgt_row),
      .row_sum (row_sum[r])
    );
  end

  // Bias travels alongside the products so a write cannot reach a window
  // that is already past S1.
  logic                     v1, v2, v3;
  logic signed [BIAS_W-1:0] bias_s1, bias_s2;
  logic signed [ACC_W-1:0]  acc;

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      bias_s1 <= '0;
      bias_s2 <= '0;
      acc     <= '0;
    end else begin
      v1      <= iWindowValid;
      v2      <= v1;
      v3      <= v2;
      bias_s1 <= bias;
      bias_s2 <= bias_s1;
      acc     <= ACC_W'(row_sum[0]) + ACC_W'(row_sum[1]) + ACC_W'(row_sum[2])
                 + ACC_W'(bias_s2);
    end
  end

  // S4: requantise, ReLU, saturate
  logic signed [ACC_W-1:0] shifted;
  logic [OUT_W-1:0]        relu_sat;
  logic                    sat_hit;

  always_comb begin
    shifted  = acc >>> SHIFT;
    relu_sat = shifted[OUT_W-1:0];
    sat_hit  = 1'b0;
    if (shifted[ACC_W-1]) begin
      relu_sat = '0;
    end else if (shifted > OUT_MAX) begin
      relu_sat = '1;
      sat_hit  = 1'b1;
    end
  end

  logic [CNT_W-1:0] out_cnt;

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      oPixelOut   <= '0;
      oPixelValid <= 1'b0;
      oFrameDone  <= 1'b0;
      oSatFlag    <= 1'b0;
      out_cnt     <= '0;
    end else begin
      oPixelValid <= v3;
      oFrameDone  <= 1'b0;
      if (v3) begin
        oPixelOut <= relu_sat;
        if (sat_hit) oSatFlag <= 1'b1;
        if (out_cnt == CNT_LAST) begin
          out_cnt    <= '0;
          oFrameDone <= 1'b1;
        end else begin
          out_cnt <= out_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_mac_relu.sv
// Self-checking bench for conv3x3_mac_relu: directed kernel cases, weight
// write collision, random windows/writes, full-frame count and mid-stream reset.
module tb_conv3x3_mac_relu;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int SHIFT = 4;
  localparam int N_WIN = (IMG_W - 2) * (IMG_H - 2);
  localparam int LAT   = 4;

  // Clock / reset
  logic        iClk = 1'b0;
  logic        iRsn;
  logic [23:0] iWindowRow1, iWindowRow2, iWindowRow3;
  logic        iWindowValid, iWgtWrEn;
  logic [3:0]  iWgtAddr;
  logic [15:0] iWgtData;
  logic [7:0]  oPixelOut;
  logic        oPixelValid, oFrameDone, oSatFlag;

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  conv3x3_mac_relu dut (
    .iClk         (iClk),
    .iRsn         (iRsn),
    .iWindowRow1  (iWindowRow1),
    .iWindowRow2  (iWindowRow2),
    .iWindowRow3  (iWindowRow3),
    .iWindowValid (iWindowValid),
    .iWgtWrEn     (iWgtWrEn),
    .iWgtAddr     (iWgtAddr),
    .iWgtData     (iWgtData),
    .oPixelOut    (oPixelOut),
    .oPixelValid  (oPixelValid),
    .oFrameDone   (oFrameDone),
    .oSatFlag     (oSatFlag)
  );

  // Checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Reference model: kernel as plain integers, expected pixels in a queue
  int         m_w [9];
  int         m_bias;
  bit         m_sat;
  logic [7:0] m_last;
  int         m_out_cnt;
  int         pix [9];
  logic [7:0] exp_q [$];
  bit         sat_q [$];
  int         lat_q [$];
  int         n_valid = 0;
  int         n_done  = 0;

  task automatic flush_model();
    exp_q.delete();
    sat_q.delete();
    lat_q.delete();
    for (int i = 0; i < 9; i++) m_w[i] = 0;
    m_bias    = 0;
    m_sat     = 1'b0;
    m_last    = '0;
    m_out_cnt = 0;
  endtask

  // Scoreboard / monitor, sampled on the falling edge
  always @(negedge iClk) begin
    if (iRsn) begin
      if (oPixelValid) begin
        n_valid++;
        if (oFrameDone) n_done++;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(oPixelValid), 32'd0);
        end else begin
          logic [7:0] e;
          bit         s;
          int         c;
          e = exp_q.pop_front();
          s = sat_q.pop_front();
          c = lat_q.pop_front();
          if (s) m_sat = 1'b1;
          check("pixel", 32'(oPixelOut), 32'(e));
          check("latency", 32'(cyc - c), 32'(LAT));
          check("sat_flag", 32'(oSatFlag), 32'(m_sat));
          check("frame_done", 32'(oFrameDone), 32'(m_out_cnt == N_WIN - 1));
          m_out_cnt = (m_out_cnt == N_WIN - 1) ? 0 : m_out_cnt + 1;
          m_last    = e;
        end
      end else begin
        check("hold", 32'(oPixelOut), 32'(m_last));
        if (oFrameDone) check("done_without_valid", 32'(oFrameDone), 32'd0);
      end
    end
  end

  // Drivers: one clock cycle of stimulus, model updated with pre-write weights
  task automatic drive(input bit win_v, input bit wr, input int addr, input int data);
    int acc, s;
    iWindowRow1  = {8'(pix[0]), 8'(pix[1]), 8'(pix[2])};
    iWindowRow2  = {8'(pix[3]), 8'(pix[4]), 8'(pix[5])};
    iWindowRow3  = {8'(pix[6]), 8'(pix[7]), 8'(pix[8])};
    iWindowValid = win_v;
    iWgtWrEn     = wr;
    iWgtAddr     = 4'(addr);
    iWgtData     = 16'(data);
    if (win_v) begin
      acc = m_bias;
      for (int i = 0; i < 9; i++) acc += pix[i] * m_w[i];
      s = acc >>> SHIFT;
      if (s < 0) begin
        exp_q.push_back(8'd0);
        sat_q.push_back(1'b0);
      end else if (s > 255) begin
        exp_q.push_back(8'd255);
        sat_q.push_back(1'b1);
      end else begin
        exp_q.push_back(8'(s));
        sat_q.push_back(1'b0);
      end
      lat_q.push_back(cyc);
    end
    if (wr && addr == 9) m_bias = int'($signed(16'(data)));
    else if (wr && addr < 9) m_w[addr] = int'($signed(8'(data)));
    @(posedge iClk);
    #1;
    iWindowValid = 1'b0;
    iWgtWrEn     = 1'b0;
  endtask

  task automatic write_wgt(input int addr, input int data);
    drive(1'b0, 1'b1, addr, data);
  endtask

  task automatic load_kernel(input int w, input int b);
    for (int i = 0; i < 9; i++) write_wgt(i, w);
    write_wgt(9, b);
  endtask

  task automatic set_pix(input int v);
    for (int i = 0; i < 9; i++) pix[i] = v;
  endtask

  task automatic rand_pix();
    for (int i = 0; i < 9; i++) pix[i] = int'($urandom_range(0, 255));
  endtask

  task automatic drain();
    int budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge iClk);
      #1;
      budget--;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge iClk);
    #1;
  endtask

  task automatic do_reset();
    iRsn = 1'b0;
    flush_model();
    repeat (2) @(posedge iClk);
    #1;
    iRsn = 1'b1;
    @(posedge iClk);
    #1;
  endtask

  int v_before;

  initial begin
    iRsn = 1'b0;
    iWindowRow1 = '0; iWindowRow2 = '0; iWindowRow3 = '0;
    iWindowValid = 1'b0; iWgtWrEn = 1'b0; iWgtAddr = '0; iWgtData = '0;
    set_pix(0);
    do_reset();

    // Reset state
    check("rst_pixel", 32'(oPixelOut), 32'd0);
    check("rst_valid", 32'(oPixelValid), 32'd0);
    check("rst_done", 32'(oFrameDone), 32'd0);
    check("rst_sat", 32'(oSatFlag), 32'd0);

    // Identity kernel
    write_wgt(4, 16);
    rand_pix();
    pix[4] = 8'h5A;
    drive(1'b1, 1'b0, 0, 0);
    drain();
    check("identity", 32'(oPixelOut), 32'h5A);
    check("identity_sat", 32'(oSatFlag), 32'd0);

    // All ones, pixels 255: acc 2295 -> 143
    load_kernel(1, 0);
    set_pix(255);
    drive(1'b1, 1'b0, 0, 0);
    drain();
    check("all_ones", 32'(oPixelOut), 32'd143);

    // All -1, pixels 10: negative -> ReLU 0
    load_kernel(-1, 0);
    set_pix(10);
    drive(1'b1, 1'b0, 0, 0);
    drain();
    check("relu", 32'(oPixelOut), 32'd0);

    // Saturation and sticky flag
    load_kernel(127, 16'h7FFF);
    set_pix(255);
    drive(1'b1, 1'b0, 0, 0);
    drain();
    check("saturate", 32'(oPixelOut), 32'd255);
    check("sat_set", 32'(oSatFlag), 32'd1);
    load_kernel(0, 0);
    drive(1'b1, 1'b0, 0, 0);
    drain();
    check("sat_sticky", 32'(oSatFlag), 32'd1);

    // Write on the same edge as a window: window sees the old centre weight
    write_wgt(4, 16);
    set_pix(0);
    pix[4] = 40;
    drive(1'b1, 1'b1, 4, 32);
    drive(1'b1, 1'b0, 0, 0);
    drain();
    check("collision_next", 32'(oPixelOut), 32'd80);

    // Random kernels, windows, bubbles and writes (including ignored addresses)
    for (int i = 0; i < 9; i++) write_wgt(i, int'($urandom_range(0, 255)) - 128);
    write_wgt(9, int'($urandom_range(0, 4000)) - 2000);
    for (int k = 0; k < 80; k++) begin
      rand_pix();
      if ($urandom_range(0, 4) == 0)
        drive(1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(0, 15)),
              int'($urandom_range(0, 65535)));
      else
        drive(1'($urandom_range(0, 3) != 0), 1'b0, 0, 0);
    end
    drain();

    // Full frame with bubbles, then a few windows of frame 2
    do_reset();
    for (int i = 0; i < 9; i++) write_wgt(i, int'($urandom_range(0, 8)) - 2);
    write_wgt(9, int'($urandom_range(0, 200)) - 100);
    n_valid = 0;
    n_done  = 0;
    for (int k = 0; k < N_WIN + 10; k++) begin
      while ($urandom_range(0, 3) == 0) drive(1'b0, 1'b0, 0, 0);
      rand_pix();
      drive(1'b1, 1'b0, 0, 0);
    end
    drain();
    check("frame_valids", 32'(n_valid), 32'(N_WIN + 10));
    check("frame_done_count", 32'(n_done), 32'd1);

    // Asynchronous reset with three windows in flight
    load_kernel(3, 0);
    for (int k = 0; k < 3; k++) begin
      set_pix(100 + k);
      drive(1'b1, 1'b0, 0, 0);
    end
    #2;
    iRsn = 1'b0;
    flush_model();
    #1;
    check("arst_pixel", 32'(oPixelOut), 32'd0);
    check("arst_valid", 32'(oPixelValid), 32'd0);
    check("arst_done", 32'(oFrameDone), 32'd0);
    check("arst_sat", 32'(oSatFlag), 32'd0);
    repeat (2) @(posedge iClk);
    #1;
    iRsn = 1'b1;
    v_before = n_valid;
    repeat (10) @(posedge iClk);
    #1;
    check("arst_no_valid", 32'(n_valid - v_before), 32'd0);

    // Weights were cleared: identity window without reload gives 0
    set_pix(255);
    pix[4] = 8'h5A;
    drive(1'b1, 1'b0, 0, 0);
    drain();
    check("cleared_kernel", 32'(oPixelOut), 32'd0);
    check("cleared_valid_count", 32'(n_valid - v_before), 32'd1);
    write_wgt(4, 16);
    drive(1'b1, 1'b0, 0, 0);
    drain();
    check("reloaded_identity", 32'(oPixelOut), 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
